// File: rtl/spi_peripheral_core.sv
// SPI peripheral (target) endpoint: oversamples SCLK/CS/MOSI in the clk domain,
// shifts bytes in and out MSB first, and exchanges them with the fabric via valid/ready.
module spi_peripheral_core #(
  parameter bit                CPOL      = 1'b0,
  parameter bit                CPHA      = 1'b0,
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] IDLE_BYTE = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_clk,
  input  logic              spi_cs,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              rx_overrun,
  input  logic              rx_ack,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t state_q, state_d;

  // Synchronizer chains: stages [1:0] synchronize, stage [2] is the edge-detect reference.
  logic [2:0] sclk_sync;
  logic [2:0] cs_sync;
  logic [1:0] mosi_sync;

  logic lead_edge, trail_edge, sample_edge, shift_edge;
  logic cs_fall, cs_rise, mosi_bit;

  logic [DATA_W-1:0] shift_tx;
  logic [DATA_W-2:0] shift_rx;
  logic [DATA_W-1:0] rx_next;
  logic [DATA_W-1:0] hold_reg;
  logic              hold_full;
  logic              pending;
  logic              first_lead;
  logic              reload_pend;
  logic [CNT_W-1:0]  bit_cnt;

  logic start_frame, end_frame, smp_en, shf_en;
  logic load_tx, shift_en, byte_done;

  // Synchronizers reset to the idle levels so that reset release never looks like an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync <= {3{CPOL}};
      cs_sync   <= 3'b111;
      mosi_sync <= 2'b00;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every stage samples the
      // pre-edge value of its neighbour; blocking here would collapse the chain.
      sclk_sync <= {sclk_sync[1:0], spi_clk};
      cs_sync   <= {cs_sync[1:0], spi_cs};
      mosi_sync <= {mosi_sync[0], spi_mosi};
    end
  end

  assign lead_edge   = (sclk_sync[1] != CPOL) && (sclk_sync[2] == CPOL);
  assign trail_edge  = (sclk_sync[1] == CPOL) && (sclk_sync[2] != CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign cs_fall     = !cs_sync[1] && cs_sync[2];
  assign cs_rise     = cs_sync[1] && !cs_sync[2];
  assign mosi_bit    = mosi_sync[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // A CS release takes priority over any SCLK edge detected in the same cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d     = state_q;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    smp_en      = 1'b0;
    shf_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d     = ACTIVE;
          start_frame = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d   = IDLE;
          end_frame = 1'b1;
        end else begin
          smp_en = sample_edge;
          shf_en = shift_edge;
        end
      end
    endcase
  end

  // A shift edge that follows a completed byte reloads instead of shifting; with CPHA=1 the
  // first leading edge of a frame is skipped because bit 0 was already presented at CS fall.
  assign load_tx   = start_frame || (shf_en && reload_pend);
  assign shift_en  = shf_en && !reload_pend && !first_lead;
  assign byte_done = smp_en && (bit_cnt == LAST_BIT);
  assign rx_next   = {shift_rx, mosi_bit};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_tx    <= '0;
      shift_rx    <= '0;
      hold_reg    <= '0;
      hold_full   <= 1'b0;
      pending     <= 1'b0;
      first_lead  <= 1'b0;
      reload_pend <= 1'b0;
      bit_cnt     <= '0;
      miso_oe     <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      rx_overrun  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      rx_overrun  <= 1'b0;
      frame_err   <= 1'b0;

      if (load_tx) begin
        if (hold_full) begin
          shift_tx <= hold_reg;
        end else begin
          shift_tx    <= IDLE_BYTE;
          tx_underrun <= 1'b1;
        end
      end else if (shift_en) begin
        shift_tx <= {shift_tx[DATA_W-2:0], 1'b0};
      end

      // A write arriving while the held byte moves out is refused; tx_ready is still low.
      if (load_tx && hold_full) begin
        hold_full <= 1'b0;
      end else if (tx_valid && !hold_full) begin
        hold_full <= 1'b1;
        hold_reg  <= tx_data;
      end

      if (start_frame) begin
        miso_oe     <= 1'b1;
        bit_cnt     <= '0;
        shift_rx    <= '0;
        first_lead  <= CPHA;
        reload_pend <= 1'b0;
      end

      if (end_frame) begin
        miso_oe     <= 1'b0;
        bit_cnt     <= '0;
        first_lead  <= 1'b0;
        reload_pend <= 1'b0;
        frame_err   <= (bit_cnt != '0);
      end

      if (smp_en) begin
        shift_rx <= rx_next[DATA_W-2:0];
        if (byte_done) begin
          bit_cnt     <= '0;
          rx_data     <= rx_next;
          rx_valid    <= 1'b1;
          rx_overrun  <= pending;
          reload_pend <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end

      if (shf_en) begin
        if (reload_pend)     reload_pend <= 1'b0;
        else if (first_lead) first_lead  <= 1'b0;
      end

      if (byte_done)   pending <= 1'b1;
      else if (rx_ack) pending <= 1'b0;
    end
  end

  assign tx_ready = !hold_full;
  assign spi_miso = miso_oe && shift_tx[DATA_W-1];

endmodule

// File: tb/tb_spi_peripheral_core.sv
// Bench for spi_peripheral_core: a mode-0 and a mode-3 instance driven by a behavioural SPI
// master, with a per-byte holding-register / pending-flag model predicting every output.
module tb_spi_peripheral_core;

  localparam int HP = 8;  // SCLK half period in clk cycles

  logic clk = 1'b0;
  logic rst;
  logic [1:0] sclk, cs, mosi, tx_valid, rx_ack;
  logic [7:0] tx_data0, tx_data1;
  wire  [1:0] miso, oe, tx_ready, rx_valid, udr, ovr, ferr;
  wire  [7:0] rx_data0, rx_data1;

  always #5 clk = ~clk;

  spi_peripheral_core #(.CPOL(1'b0), .CPHA(1'b0), .DATA_W(8), .IDLE_BYTE(8'hFF)) u_dut0 (
    .clk(clk), .rst(rst), .spi_clk(sclk[0]), .spi_cs(cs[0]), .spi_mosi(mosi[0]),
    .spi_miso(miso[0]), .miso_oe(oe[0]), .tx_data(tx_data0), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .rx_data(rx_data0), .rx_valid(rx_valid[0]),
    .tx_underrun(udr[0]), .rx_overrun(ovr[0]), .rx_ack(rx_ack[0]), .frame_err(ferr[0]));

  spi_peripheral_core #(.CPOL(1'b1), .CPHA(1'b1), .DATA_W(8), .IDLE_BYTE(8'hFF)) u_dut1 (
    .clk(clk), .rst(rst), .spi_clk(sclk[1]), .spi_cs(cs[1]), .spi_mosi(mosi[1]),
    .spi_miso(miso[1]), .miso_oe(oe[1]), .tx_data(tx_data1), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .rx_data(rx_data1), .rx_valid(rx_valid[1]),
    .tx_underrun(udr[1]), .rx_overrun(ovr[1]), .rx_ack(rx_ack[1]), .frame_err(ferr[1]));

  int total = 0;
  int bad   = 0;

  // Pulse counters observed on the DUT outputs.
  int rxv_cnt [2] = '{0, 0};
  int ovr_cnt [2] = '{0, 0};
  int udr_cnt [2] = '{0, 0};
  int ferr_cnt[2] = '{0, 0};

  // Reference model: one-entry holding register, pending flag, expected pulse totals.
  logic       m_full[2] = '{1'b0, 1'b0};
  logic [7:0] m_val [2] = '{8'h00, 8'h00};
  logic       m_pend[2] = '{1'b0, 1'b0};
  int exp_rxv [2] = '{0, 0};
  int exp_ovr [2] = '{0, 0};
  int exp_udr [2] = '{0, 0};
  int exp_ferr[2] = '{0, 0};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rx_valid[i] === 1'b1) rxv_cnt[i]++;
      if (ovr[i] === 1'b1)      ovr_cnt[i]++;
      if (udr[i] === 1'b1)      udr_cnt[i]++;
      if (ferr[i] === 1'b1)     ferr_cnt[i]++;
    end
  end

  function automatic logic cpol(input int d);
    return (d == 1);
  endfunction

  function automatic logic cpha(input int d);
    return (d == 1);
  endfunction

  function automatic logic [7:0] rxd(input int d);
    return (d == 1) ? rx_data1 : rx_data0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // A byte slot takes the held value if one is queued, otherwise the idle byte and an underrun.
  task automatic mload(input int d, output logic [7:0] v);
    if (m_full[d]) begin
      v = m_val[d];
      m_full[d] = 1'b0;
    end else begin
      v = 8'hFF;
      exp_udr[d]++;
    end
  endtask

  task automatic push(input int d, input logic [7:0] v);
    int waited = 0;
    while (tx_ready[d] !== 1'b1 && waited < 32) begin
      clks(1);
      waited++;
    end
    chk("tx_ready_before_push", tx_ready[d], 1'b1);
    if (d == 1) tx_data1 = v; else tx_data0 = v;
    tx_valid[d] = 1'b1;
    clks(1);
    tx_valid[d] = 1'b0;
    m_full[d] = 1'b1;
    m_val[d]  = v;
    chk("tx_ready_after_push", tx_ready[d], 1'b0);
  endtask

  // Clocks nbits of one byte MSB first; an optional push happens during the first bit.
  task automatic xfer(input int d, input logic [7:0] mo, input int nbits,
                      input bit do_push, input logic [7:0] pv, output logic [7:0] mi);
    mi = 8'h00;
    for (int b = 0; b < nbits; b++) begin
      if (!cpha(d)) begin
        mosi[d] = mo[7-b];
        clks(HP);
        if (b == 0 && do_push) push(d, pv);
        mi[7-b] = miso[d];
        sclk[d] = ~cpol(d);
        clks(HP);
        sclk[d] = cpol(d);
      end else begin
        sclk[d] = ~cpol(d);
        mosi[d] = mo[7-b];
        clks(HP);
        if (b == 0 && do_push) push(d, pv);
        mi[7-b] = miso[d];
        sclk[d] = cpol(d);
        clks(HP);
      end
    end
  endtask

  // give[k]: slot k is queued (slot 0 before CS falls, slot k>0 during byte k-1).
  task automatic run_frame(input int d, input int nb, input int last_bits,
                           input logic [2:0][7:0] mo, input logic [2:0] give,
                           input logic [2:0][7:0] gv, input bit do_ack);
    logic [7:0] exp_tx[4];
    logic [7:0] mi;
    int bits;
    if (give[0]) push(d, gv[0]);
    cs[d] = 1'b0;
    mload(d, exp_tx[0]);
    clks(HP);
    chk("miso_oe_active", oe[d], 1'b1);
    for (int k = 0; k < nb; k++) begin
      bits = (k == nb - 1) ? last_bits : 8;
      if (k > 0 && cpha(d)) mload(d, exp_tx[k]);
      xfer(d, mo[k], bits, (k + 1 < nb) && give[k+1], gv[(k + 1) % 3], mi);
      if (bits == 8) begin
        exp_rxv[d]++;
        if (m_pend[d]) exp_ovr[d]++;
        m_pend[d] = 1'b1;
        chk("miso_byte", mi, exp_tx[k]);
        chk("rx_valid_count", rxv_cnt[d], exp_rxv[d]);
        chk("rx_data", rxd(d), mo[k]);
        chk("rx_overrun_count", ovr_cnt[d], exp_ovr[d]);
        if (do_ack) begin
          rx_ack[d] = 1'b1;
          clks(1);
          rx_ack[d] = 1'b0;
          m_pend[d] = 1'b0;
        end
        if (!cpha(d)) mload(d, exp_tx[k+1]);
      end
    end
    clks(HP);
    cs[d] = 1'b1;
    clks(HP);
    if (last_bits != 8) exp_ferr[d]++;
    chk("miso_oe_idle", oe[d], 1'b0);
    chk("miso_idle", miso[d], 1'b0);
    chk("frame_err_count", ferr_cnt[d], exp_ferr[d]);
    chk("tx_underrun_count", udr_cnt[d], exp_udr[d]);
    chk("rx_valid_total", rxv_cnt[d], exp_rxv[d]);
  endtask

  initial begin
    logic [7:0] mi;
    logic [2:0][7:0] r_mo, r_gv;
    logic [2:0] r_give;
    int rd, rnb, rlast;

    rst = 1'b0;
    sclk = 2'b10;
    cs = 2'b11;
    mosi = 2'b00;
    tx_valid = 2'b00;
    rx_ack = 2'b00;
    tx_data0 = 8'h00;
    tx_data1 = 8'h00;
    clks(3);

    for (int d = 0; d < 2; d++) begin
      chk("rst_miso", miso[d], 1'b0);
      chk("rst_miso_oe", oe[d], 1'b0);
      chk("rst_tx_ready", tx_ready[d], 1'b1);
      chk("rst_rx_data", rxd(d), 8'h00);
      chk("rst_pulses", {rx_valid[d], udr[d], ovr[d], ferr[d]}, 4'b0000);
    end
    rst = 1'b1;
    clks(4);

    // Mode 0: queued A5 goes out while 3C comes in.
    run_frame(0, 1, 8, {8'h00, 8'h00, 8'h3C}, 3'b001, {8'h00, 8'h00, 8'hA5}, 1'b1);
    chk("tx_ready_reasserted", tx_ready[0], 1'b1);

    // Mode 3: three bytes back to back, TX queued just in time.
    run_frame(1, 3, 8, {8'hFF, 8'h80, 8'h01}, 3'b111, {8'h33, 8'h22, 8'h11}, 1'b1);

    // Empty TX queue: idle byte and an underrun.
    run_frame(1, 1, 8, {8'h00, 8'h00, 8'h55}, 3'b000, '0, 1'b1);

    // CS released after five bits, then a clean byte.
    run_frame(1, 1, 5, {8'h00, 8'h00, 8'hC3}, 3'b000, '0, 1'b1);
    run_frame(1, 1, 8, {8'h00, 8'h00, 8'hC3}, 3'b000, '0, 1'b1);

    // Two bytes without acknowledge: second one overruns.
    run_frame(0, 2, 8, {8'h00, 8'h34, 8'h12}, 3'b000, '0, 1'b0);
    rx_ack[0] = 1'b1;
    clks(1);
    rx_ack[0] = 1'b0;
    m_pend[0] = 1'b0;

    // Reset asserted mid-byte takes effect without a clock edge.
    cs[0] = 1'b0;
    mload(0, mi);
    clks(HP);
    xfer(0, 8'hAB, 4, 1'b0, 8'h00, mi);
    #2 rst = 1'b0;
    #1;
    chk("midrst_miso", miso[0], 1'b0);
    chk("midrst_miso_oe", oe[0], 1'b0);
    chk("midrst_tx_ready", tx_ready[0], 1'b1);
    chk("midrst_rx_data", rx_data0, 8'h00);
    chk("midrst_pulses", {rx_valid[0], udr[0], ovr[0], ferr[0]}, 4'b0000);
    cs[0] = 1'b1;
    for (int d = 0; d < 2; d++) begin
      m_full[d] = 1'b0;
      m_pend[d] = 1'b0;
    end
    clks(3);
    rst = 1'b1;
    clks(4);
    run_frame(0, 1, 8, {8'h00, 8'h00, 8'h96}, 3'b000, '0, 1'b1);

    // Random frames on either mode.
    for (int f = 0; f < 8; f++) begin
      rd     = $urandom_range(0, 1);
      rnb    = $urandom_range(1, 3);
      rlast  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8;
      r_mo   = 24'($urandom);
      r_gv   = 24'($urandom);
      r_give = 3'($urandom);
      run_frame(rd, rnb, rlast, r_mo, r_give, r_gv, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
